i2c_master_sequencer: RTL and testbench
=======================================

// Module: i2c_master_sequencer
// PURPOSE
//  Byte-level I2C master. Consumes slot strobes from the I2C clock unit and drives open-drain SCL/SDA.
//  - Slot: 500 clk = 5 us at 100 MHz. Each bit takes two slots (LO, HI), giving 100 kHz SCL.
//  - Executes one command at a time: START, WRITE byte, READ byte, STOP.
//  - Sits between the CPU bus I2C register block (command side) and the pad open-drain buffers.
// PARAMETERS
//  SYNC_STAGES  2  flop stages on sdaIn/sclIn before use (min 2)
// PORTS
//  clk         in   1  system clock (100 MHz)
//  reset       in   1  asynchronous, active-high reset
//  firstCycle  in   1  slot strobe: first cycle of slot
//  dataCycle   in   1  slot strobe: cycle 100 of slot, SDA update/sample point
//  finalCycle  in   1  slot strobe: last cycle of slot
//  cmdValid    in   1  command request
//  cmdReady    out  1  high only in IDLE
//  cmd         in   2  00 START, 01 WRITE, 10 READ, 11 STOP
//  txData      in   8  WRITE byte, sent MSB first
//  ackTx       in   1  master ACK bit for READ (0 = ACK, 1 = NACK)
//  rxData      out  8  READ result, valid from done
//  ackRx       out  1  slave ACK sampled after WRITE (0 = ACK)
//  done        out  1  1-cycle pulse at command completion
//  busOwned    out  1  1 from START until STOP completes
//  sclOe       out  1  1 = pull SCL low
//  sdaOe       out  1  1 = pull SDA low
//  sdaIn       in   1  SDA pad value (async)
//  sclIn       in   1  SCL pad value (async; used only by arbitration)
// BEHAVIOUR
//  - Reset, asynchronous: state=IDLE; sclOe=0; sdaOe=0; busOwned=0; done=0; rxData=0; ackRx=1.
//    Reset mid-command releases both lines the same cycle; no STOP is generated.
//  - Handshake: accept on cmdValid && cmdReady. cmd, txData and ackTx are latched at accept; state -> ARM.
//  - ARM: on finalCycle, enter the first slot state, so every slot state begins on firstCycle.
//  - All slot states advance on finalCycle. Slot-state actions:
//    - LO slots: sclOe=1 from firstCycle; SDA is changed at dataCycle.
//    - HI slots: sclOe=0 from firstCycle; SDA is sampled or changed at dataCycle.
//  - START: if busOwned, START_LO first (release SDA) for a repeated start; otherwise go straight to START_HI.
//    START_HI sets sdaOe=1 at dataCycle, then busOwned=1.
//  - WRITE: 8x (BIT_LO: sdaOe=~txData[bit]; BIT_HI), then ACK_LO (sdaOe=0), then ACK_HI (ackRx=sdaIn_sync).
//  - READ: 8x (BIT_LO: sdaOe=0; BIT_HI: shift sdaIn_sync into rxData LSB), then ACK_LO (sdaOe=~ackTx), then ACK_HI.
//  - STOP: STOP_LO (sdaOe=1), then STOP_HI (sclOe=0; sdaOe=0 at dataCycle), then busOwned=0.
//  - Completion: done pulses in the cycle after the last slot's finalCycle; state -> IDLE.
//  - IDLE: if busOwned, sclOe=1 and SDA held; otherwise both lines released.
//  - Bit counter: 3 bits, counts 7 down to 0, decrements in HI slots; wraps only via re-load.
//  - Illegal sequences: WRITE/READ/STOP with busOwned=0 completes as a no-op; done pulses after ARM, lines untouched.
//  - A strobe arriving during IDLE is ignored. cmdValid while busy is held off (cmdReady=0).
//  - WRITE latency: 18 slots (9000 clk) from first firstCycle to done.
// CONFIGURATION
//  I2C_ARB_LOST_EN
//   - Defined: adds output arbLost (1 bit, reset 0).
//     - Trigger: in a WRITE BIT_HI with sdaOe=0, sdaIn_sync=0 at dataCycle.
//     - Response: release both lines at once, busOwned=0, arbLost=1, done pulses, state -> IDLE.
//     - Clear: arbLost clears at the next accepted command.
//   - Undefined: no port, no check.
// STRUCTURE
//  - Package i2c_pkg:
//    - i2c_cmd_t enum: START, WRITE, READ, STOP.
//    - i2c_state_t enum: IDLE, ARM, START_LO, START_HI, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_LO, STOP_HI.
//    - I2C_BITS=8.
//  - Sub-module i2c_sync: SYNC_STAGES-deep flop chain, one instance each for sdaIn and sclIn.
//  - Strobes come from the clock unit instantiated in the parent; this block does no counting of its own.
// TESTING
//  1. Reset asserted mid-WRITE -> sclOe=0, sdaOe=0, busOwned=0 the same cycle; cmdReady=1 after release.
//  2. START from idle -> sdaOe rises at dataCycle of the first slot while sclOe=0; done; busOwned=1.
//  3. WRITE 0xA5, bus model ACKs -> sdaOe in BIT_LO slots = 0,1,0,1,1,0,1,0; ackRx=0; done 9000 clk after first slot.
//  4. READ, model drives 0x3C, ackTx=1 -> rxData=0x3C; sdaOe=0 during ACK slots; ackRx unchanged.
//  5. START while busOwned, then STOP -> START_LO inserted (repeated start); STOP ends with sdaOe=0 with SCL released; busOwned=0.
//  6. I2C_ARB_LOST_EN: WRITE 0xFF, model pulls SDA low on bit 6 -> arbLost=1, lines released, done; without macro the WRITE completes.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C master sequencer.
package i2c_pkg;

    localparam int unsigned I2C_BITS  = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        START = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10,
        STOP  = 2'b11
    } i2c_cmd_t;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        START_LO,
        START_HI,
        BIT_LO,
        BIT_HI,
        ACK_LO,
        ACK_HI,
        STOP_LO,
        STOP_HI
    } i2c_state_t;

    function automatic logic is_lo_slot(input i2c_state_t s);
        return (s == START_LO) || (s == BIT_LO) || (s == ACK_LO) || (s == STOP_LO);
    endfunction

    function automatic logic is_hi_slot(input i2c_state_t s);
        return (s == START_HI) || (s == BIT_HI) || (s == ACK_HI) || (s == STOP_HI);
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// Multi-stage synchroniser for an asynchronous pad input; resets to the released (high) level.
module i2c_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/i2c_master_sequencer.sv
// Byte-level I2C master: sequences START/WRITE/READ/STOP over slot strobes onto open-drain SCL/SDA.
// Optional arbitration-lost detection is built when I2C_ARB_LOST_EN is defined.
module i2c_master_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                firstCycle,
    input  logic                dataCycle,
    input  logic                finalCycle,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [1:0]          cmd,
    input  logic [I2C_BITS-1:0] txData,
    input  logic                ackTx,
    output logic [I2C_BITS-1:0] rxData,
    output logic                ackRx,
    output logic                done,
    output logic                busOwned,
    output logic                sclOe,
    output logic                sdaOe,
    input  logic                sdaIn,
    input  logic                sclIn
`ifdef I2C_ARB_LOST_EN
    ,
    output logic                arbLost
`endif
);

    i2c_state_t            state, next_state;
    i2c_cmd_t              cmd_q;
    logic [I2C_BITS-1:0]   tx_q;
    logic                  ack_tx_q;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  sda_sync;
    logic                  scl_sync;
    logic                  scl_unused;
`ifdef I2C_ARB_LOST_EN
    logic                  arb_hit;
`endif

    i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (.clk(clk), .reset(reset), .d(sdaIn), .q(sda_sync));
    i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (.clk(clk), .reset(reset), .d(sclIn), .q(scl_sync));

    // SCL readback is reserved for arbitration/stretch extensions; not consumed by the sequencer.
    assign scl_unused = scl_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Slot sequencing: every slot state advances on finalCycle.
    always_comb begin
        next_state = state;
`ifdef I2C_ARB_LOST_EN
        arb_hit    = 1'b0;
`endif
        case (state)
            IDLE:     if (cmdValid) next_state = ARM;
            ARM: begin
                if (finalCycle) begin
                    case (cmd_q)
                        START:       next_state = busOwned ? START_LO : START_HI;
                        WRITE, READ: next_state = busOwned ? BIT_LO   : IDLE;
                        default:     next_state = busOwned ? STOP_LO  : IDLE;
                    endcase
                end
            end
            START_LO: if (finalCycle) next_state = START_HI;
            START_HI: if (finalCycle) next_state = IDLE;
            BIT_LO:   if (finalCycle) next_state = BIT_HI;
            BIT_HI: begin
`ifdef I2C_ARB_LOST_EN
                if (dataCycle && (cmd_q == WRITE) && !sdaOe && !sda_sync) begin
                    arb_hit    = 1'b1;
                    next_state = IDLE;
                end else
`endif
                if (finalCycle) begin
                    next_state = (bit_cnt == '0) ? ACK_LO : BIT_LO;
                end
            end
            ACK_LO:   if (finalCycle) next_state = ACK_HI;
            ACK_HI:   if (finalCycle) next_state = IDLE;
            STOP_LO:  if (finalCycle) next_state = STOP_HI;
            STOP_HI:  if (finalCycle) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmdReady <= 1'b1;
            done     <= 1'b0;
            busOwned <= 1'b0;
            sclOe    <= 1'b0;
            sdaOe    <= 1'b0;
            rxData   <= '0;
            ackRx    <= 1'b1;
            cmd_q    <= START;
            tx_q     <= '0;
            ack_tx_q <= 1'b1;
            bit_cnt  <= '0;
`ifdef I2C_ARB_LOST_EN
            arbLost  <= 1'b0;
`endif
        end else begin
            cmdReady <= (next_state == IDLE);
            done     <= (state != IDLE) && (next_state == IDLE);

            if (state == IDLE) begin
                sclOe <= busOwned;
                if (!busOwned) sdaOe <= 1'b0;
                if (cmdValid) begin
                    cmd_q    <= i2c_cmd_t'(cmd);
                    tx_q     <= txData;
                    ack_tx_q <= ackTx;
                    bit_cnt  <= BIT_CNT_W'(I2C_BITS - 1);
`ifdef I2C_ARB_LOST_EN
                    arbLost  <= 1'b0;
`endif
                end
            end

            if (firstCycle) begin
                if (is_lo_slot(state))      sclOe <= 1'b1;
                else if (is_hi_slot(state)) sclOe <= 1'b0;
            end

            // SDA is only changed or sampled at the data point of a slot.
            if (dataCycle) begin
                case (state)
                    START_LO: sdaOe <= 1'b0;
                    START_HI: sdaOe <= 1'b1;
                    BIT_LO:   sdaOe <= (cmd_q == WRITE) ? ~tx_q[bit_cnt] : 1'b0;
                    BIT_HI:   if (cmd_q == READ) rxData <= {rxData[I2C_BITS-2:0], sda_sync};
                    ACK_LO:   sdaOe <= (cmd_q == WRITE) ? 1'b0 : ~ack_tx_q;
                    ACK_HI:   if (cmd_q == WRITE) ackRx <= sda_sync;
                    STOP_LO:  sdaOe <= 1'b1;
                    STOP_HI:  sdaOe <= 1'b0;
                    default:  ;
                endcase
            end

            if (finalCycle) begin
                if (state == START_HI) busOwned <= 1'b1;
                if (state == STOP_HI)  busOwned <= 1'b0;
                if ((state == BIT_HI) && (bit_cnt != '0)) bit_cnt <= bit_cnt - BIT_CNT_W'(1);
            end

`ifdef I2C_ARB_LOST_EN
            if (arb_hit) begin
                sclOe    <= 1'b0;
                sdaOe    <= 1'b0;
                busOwned <= 1'b0;
                arbLost  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for i2c_master_sequencer: bench-generated 500-clk slots and an open-drain bus/slave model.
module tb_i2c_master_sequencer;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmdValid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] txData = 8'h00;
    logic       ackTx = 1'b0;
    logic       slave_pull = 1'b0;
    logic       firstCycle, dataCycle, finalCycle;
    logic       cmdReady, ackRx, done, busOwned, sclOe, sdaOe, sdaIn, sclIn;
    logic [7:0] rxData;
`ifdef I2C_ARB_LOST_EN
    logic       arbLost;
`endif

    int unsigned slot_cnt = 0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        slot_cnt <= (slot_cnt == 499) ? 0 : slot_cnt + 1;
        cyc      <= cyc + 1;
    end

    assign firstCycle = (slot_cnt == 0);
    assign dataCycle  = (slot_cnt == 100);
    assign finalCycle = (slot_cnt == 499);
    assign sdaIn      = ~(sdaOe | slave_pull);
    assign sclIn      = ~sclOe;

    i2c_master_sequencer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .firstCycle(firstCycle), .dataCycle(dataCycle), .finalCycle(finalCycle),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmd(cmd), .txData(txData), .ackTx(ackTx),
        .rxData(rxData), .ackRx(ackRx), .done(done), .busOwned(busOwned),
        .sclOe(sclOe), .sdaOe(sdaOe), .sdaIn(sdaIn), .sclIn(sclIn)
`ifdef I2C_ARB_LOST_EN
        , .arbLost(arbLost)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Returns right after the posedge on which the DUT saw finalCycle.
    task automatic wait_final();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if (slot_cnt == 499) return;
        end
        check("slot_timeout", 0, 1);
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        cmdValid = 1'b1; cmd = c; txData = d; ackTx = a;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk);
            if (cmdReady) ok = 1'b1;
        end
        #1 cmdValid = 1'b0;
        check("accept", 32'(ok), 1);
    endtask

    task automatic slot(input logic pull, output logic scl_s, output logic sda_e, output logic sda_s);
        slave_pull = pull;
        while (slot_cnt != 50) @(negedge clk);
        sda_e = sdaOe;
        while (slot_cnt != 300) @(negedge clk);
        scl_s = sclOe;
        sda_s = sdaOe;
        wait_final();
    endtask

    // Issue one command, step n slots with the given slave pulls (bit k = slot k), then check done.
    task automatic run(input logic [1:0] c, input logic [7:0] d, input logic a, input int n,
                       input logic [17:0] pulls, output logic [17:0] sclv, output logic [17:0] sdav,
                       output logic [17:0] sdaev, output int lat);
        int unsigned t0;
        logic s, e, q;
        sclv = '0; sdav = '0; sdaev = '0;
        slave_pull = 1'b0;
        issue(c, d, a);
        wait_final();
        #1 t0 = cyc;
        for (int k = 0; k < n; k++) begin
            slot(pulls[k], s, e, q);
            sclv[k] = s; sdaev[k] = e; sdav[k] = q;
        end
        slave_pull = 1'b0;
        @(negedge clk);
        lat = int'(cyc - t0);
        check("done_pulse", 32'(done), 1);
        @(negedge clk);
        check("done_single", 32'(done), 0);
    endtask

    function automatic logic [17:0] write_sda(input logic [7:0] d);
        logic [17:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v[2*i]   = ~d[7-i];
            v[2*i+1] = ~d[7-i];
        end
        return v;
    endfunction

    function automatic logic [17:0] read_pulls(input logic [7:0] d);
        logic [17:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v[2*i]   = ~d[7-i];
            v[2*i+1] = ~d[7-i];
        end
        return v;
    endfunction

    localparam logic [17:0] SCL_BYTE = 18'h15555;
    localparam logic [17:0] ACK_PULL = 18'h30000;

    initial begin
        logic [17:0] sclv, sdav, sdaev;
        logic s, e, q;
        int lat;

        #22;
        check("rst_sclOe", 32'(sclOe), 0);
        check("rst_sdaOe", 32'(sdaOe), 0);
        check("rst_busOwned", 32'(busOwned), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rxData", 32'(rxData), 0);
        check("rst_ackRx", 32'(ackRx), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmdReady", 32'(cmdReady), 1);

        // START from idle: goes straight to START_HI
        run(2'b00, 8'h00, 1'b0, 1, '0, sclv, sdav, sdaev, lat);
        check("start_scl", 32'(sclv[0]), 0);
        check("start_sda_pre", 32'(sdaev[0]), 0);
        check("start_sda_post", 32'(sdav[0]), 1);
        check("start_busOwned", 32'(busOwned), 1);
        check("idle_hold_scl", 32'(sclOe), 1);

        // Reset mid-WRITE releases both lines at once
        issue(2'b01, 8'h00, 1'b0);
        wait_final();
        for (int k = 0; k < 4; k++) slot(1'b0, s, e, q);
        while (slot_cnt != 300) @(negedge clk);
        check("midw_scl", 32'(sclOe), 1);
        check("midw_sda", 32'(sdaOe), 1);
        reset = 1'b1;
        #1;
        check("midrst_scl", 32'(sclOe), 0);
        check("midrst_sda", 32'(sdaOe), 0);
        check("midrst_bus", 32'(busOwned), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(cmdReady), 1);

        // WRITE 0xA5 with slave ACK
        run(2'b00, 8'h00, 1'b0, 1, '0, sclv, sdav, sdaev, lat);
        run(2'b01, 8'hA5, 1'b0, 18, ACK_PULL, sclv, sdav, sdaev, lat);
        check("wr_scl", 32'(sclv), 32'(SCL_BYTE));
        check("wr_sda", 32'(sdav), 32'(write_sda(8'hA5)));
        check("wr_ackRx", 32'(ackRx), 0);
        check("wr_latency", 32'(lat), 9000);

        // READ 0x3C with master NACK
        run(2'b10, 8'h00, 1'b1, 18, read_pulls(8'h3C), sclv, sdav, sdaev, lat);
        check("rd_rxData", 32'(rxData), 32'h3C);
        check("rd_scl", 32'(sclv), 32'(SCL_BYTE));
        check("rd_sda", 32'(sdav), 0);
        check("rd_ackRx_kept", 32'(ackRx), 0);

        // Repeated START inserts START_LO
        run(2'b00, 8'h00, 1'b0, 2, '0, sclv, sdav, sdaev, lat);
        check("rs_scl", 32'(sclv[1:0]), 32'h1);
        check("rs_sda", 32'(sdav[1:0]), 32'h2);
        check("rs_busOwned", 32'(busOwned), 1);

        // STOP: SDA released at the data point while SCL is released
        run(2'b11, 8'h00, 1'b0, 2, '0, sclv, sdav, sdaev, lat);
        check("stop_scl", 32'(sclv[1:0]), 32'h1);
        check("stop_sda", 32'(sdav[1:0]), 32'h1);
        check("stop_sda_pre", 32'(sdaev[1:0]), 32'h3);
        check("stop_busOwned", 32'(busOwned), 0);
        check("stop_idle_scl", 32'(sclOe), 0);
        check("stop_idle_sda", 32'(sdaOe), 0);

        // WRITE without owning the bus is a no-op
        run(2'b01, 8'h55, 1'b0, 0, '0, sclv, sdav, sdaev, lat);
        check("noop_scl", 32'(sclOe), 0);
        check("noop_sda", 32'(sdaOe), 0);
        check("noop_bus", 32'(busOwned), 0);

        // WRITE 0xFF while another master pulls SDA on bit 6
        run(2'b00, 8'h00, 1'b0, 1, '0, sclv, sdav, sdaev, lat);
`ifdef I2C_ARB_LOST_EN
        begin
            logic seen;
            seen = 1'b0;
            issue(2'b01, 8'hFF, 1'b0);
            wait_final();
            slot(1'b0, s, e, q);
            slot(1'b0, s, e, q);
            slot(1'b1, s, e, q);
            for (int i = 0; i < 600 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            slave_pull = 1'b0;
            check("arb_done", 32'(seen), 1);
            check("arb_lost", 32'(arbLost), 1);
            check("arb_scl", 32'(sclOe), 0);
            check("arb_sda", 32'(sdaOe), 0);
            check("arb_bus", 32'(busOwned), 0);
            issue(2'b11, 8'h00, 1'b0);
            check("arb_clear", 32'(arbLost), 0);
            wait_final();
            @(negedge clk);
            check("arb_stop_noop", 32'(done), 1);
        end
`else
        run(2'b01, 8'hFF, 1'b0, 18, 18'h3000C, sclv, sdav, sdaev, lat);
        check("ff_sda", 32'(sdav), 0);
        check("ff_ackRx", 32'(ackRx), 0);
        check("ff_busOwned", 32'(busOwned), 1);
        run(2'b11, 8'h00, 1'b0, 2, '0, sclv, sdav, sdaev, lat);
        check("ff_stop_bus", 32'(busOwned), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
